// File: rtl/frame_diff_detector.sv
// Per-pixel luma motion detector against the previous frame held in an internal luma RAM.
// Latency: 2 clocks from DE/x_pixel/y_pixel/imgData to de_o/x_o/y_o/motion_flag.
// Backpressure: none, one pixel accepted every clock. Optional MOTION_HFILT_EN adds a 2-tap horizontal AND filter.
module frame_diff_detector #(
    parameter int THRESH = 20,
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        DE,
    input  logic [9:0]  x_pixel,
    input  logic [9:0]  y_pixel,
    input  logic [15:0] imgData,
    output logic        de_o,
    output logic [9:0]  x_o,
    output logic [9:0]  y_o,
    output logic        motion_flag,
    output logic [16:0] frame_motion_cnt,
    output logic        prev_valid
);

    localparam int          DEPTH   = IMG_W * IMG_H;
    localparam int          RW      = $clog2(DEPTH);
    localparam logic [9:0]  DISP_W  = 10'(2 * IMG_W);
    localparam logic [9:0]  DISP_H  = 10'(2 * IMG_H);
    localparam logic [9:0]  X_LAST  = 10'(2 * IMG_W - 1);
    localparam logic [9:0]  Y_LAST  = 10'(2 * IMG_H - 1);
    localparam logic [16:0] CNT_MAX = '1;

    // input-side decode
    logic        win_in;
    logic [14:0] addr_in;
    logic [14:0] rd_addr;
    logic [7:0]  luma_in;

    // stage 1 registers
    logic        de_s1;
    logic [9:0]  x_s1;
    logic [9:0]  y_s1;
    logic        win_s1;
    logic [14:0] addr_s1;
    logic [7:0]  luma_s1;

    // luma RAM
    logic [7:0]  mem [DEPTH];
    logic [7:0]  ram_q;

    // stage 1 combinational results
    logic [7:0]  diff;
    logic        raw;
    logic        flag_d;
    logic        wr_en;
    logic        frame_end;
    logic        first_blk;
    logic [16:0] cnt_next;

    // running state
    logic [16:0] run_cnt;
    logic        seen_first;

`ifdef MOTION_HFILT_EN
    logic        raw_prev;
`endif

    // Window test, source-pixel address and luma for the incoming pixel.
    always_comb begin
        win_in  = DE && (x_pixel < DISP_W) && (y_pixel < DISP_H);
        addr_in = 15'(IMG_W * int'(y_pixel[9:1]) + int'(x_pixel[9:1]));
        // Outside the window the address can run past the RAM; park it at 0.
        rd_addr = win_in ? addr_in : '0;
        luma_in = 8'(imgData[15:11]) + 8'(imgData[10:5]) + 8'(imgData[4:0]);
    end

    // Stage 1 pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            de_s1   <= 1'b0;
            x_s1    <= '0;
            y_s1    <= '0;
            win_s1  <= 1'b0;
            addr_s1 <= '0;
            luma_s1 <= '0;
        end else begin
            de_s1   <= DE;
            x_s1    <= x_pixel;
            y_s1    <= y_pixel;
            win_s1  <= win_in;
            addr_s1 <= addr_in;
            luma_s1 <= luma_in;
        end
    end

    // Luma RAM: synchronous read for the incoming pixel, write-back from stage 1.
    // The write targets the block just finished, the read the next pixel, so they never collide.
    always_ff @(posedge clk) begin
        ram_q <= mem[rd_addr[RW-1:0]];
        if (wr_en) begin
            mem[addr_s1[RW-1:0]] <= luma_s1;
        end
    end

    // Difference, raw decision, write enable, frame-end and count update.
    always_comb begin
        diff      = (luma_s1 >= ram_q) ? (luma_s1 - ram_q) : (ram_q - luma_s1);
        raw       = win_s1 && prev_valid && (int'(diff) > THRESH);
        // Only the bottom-right pixel of each 2x2 block updates the RAM, so the
        // other three always compare against the previous frame.
        wr_en     = win_s1 && x_s1[0] && y_s1[0];
        frame_end = wr_en && (x_s1 == X_LAST) && (y_s1 == Y_LAST);
        first_blk = wr_en && (addr_s1 == '0);
`ifdef MOTION_HFILT_EN
        flag_d    = raw && raw_prev;
`else
        flag_d    = raw;
`endif
        // Counting the flag as it enters stage 2 lets the frame-end latch include the last pixel.
        cnt_next  = (run_cnt == CNT_MAX) ? run_cnt : (run_cnt + {16'd0, flag_d});
    end

    // Stage 2 output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            de_o        <= 1'b0;
            x_o         <= '0;
            y_o         <= '0;
            motion_flag <= 1'b0;
        end else begin
            de_o        <= de_s1;
            x_o         <= x_s1;
            y_o         <= y_s1;
            motion_flag <= flag_d;
        end
    end

`ifdef MOTION_HFILT_EN
    // Raw result of the previous pixel; raw is already 0 in blanking or outside the window.
    always_ff @(posedge clk) begin
        if (reset) begin
            raw_prev <= 1'b0;
        end else begin
            raw_prev <= raw;
        end
    end
`endif

    // Running counter, frame-end latch and previous-frame-valid tracking.
    // prev_valid only rises once a frame has been written from its first block,
    // so a frame cut short by reset can never validate a partly stale RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt          <= '0;
            frame_motion_cnt <= '0;
            prev_valid       <= 1'b0;
            seen_first       <= 1'b0;
        end else begin
            if (first_blk) begin
                seen_first <= 1'b1;
            end
            if (frame_end) begin
                frame_motion_cnt <= cnt_next;
                run_cnt          <= '0;
                if (seen_first || first_blk) begin
                    prev_valid <= 1'b1;
                end
            end else begin
                run_cnt <= cnt_next;
            end
        end
    end

endmodule

// File: tb/tb_frame_diff_detector.sv
// Randomised and directed bench for frame_diff_detector with a per-pixel reference model.
// Latency: model expectations are compared 2 clocks after each pixel is driven.
// Backpressure: none, one pixel driven per clock including blanking.
module tb_frame_diff_detector;

    localparam int THRESH = 20;
    localparam int IMG_W  = 16;
    localparam int IMG_H  = 8;
    localparam int DW     = 2 * IMG_W;
    localparam int DH     = 2 * IMG_H;
    localparam int HT     = 40;   // total columns per line
    localparam int VT     = 18;   // total lines per frame
    localparam int HDE    = 36;   // DE high past the window on the right
    localparam int VDE    = 17;   // one DE line below the window
    localparam int CMAX   = 131071;

`ifdef MOTION_HFILT_EN
    localparam int E_BLK = 2;
    localparam int E_THR = 4;
    localparam int E_ALL = 496;
`else
    localparam int E_BLK = 4;
    localparam int E_THR = 8;
    localparam int E_ALL = 512;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        DE = 1'b0;
    logic [9:0]  x_pixel = '0;
    logic [9:0]  y_pixel = '0;
    logic [15:0] imgData = '0;
    logic        de_o;
    logic [9:0]  x_o;
    logic [9:0]  y_o;
    logic        motion_flag;
    logic [16:0] frame_motion_cnt;
    logic        prev_valid;

    always #5 clk = ~clk;

    frame_diff_detector #(.THRESH(THRESH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk              (clk),
        .reset            (reset),
        .DE               (DE),
        .x_pixel          (x_pixel),
        .y_pixel          (y_pixel),
        .imgData          (imgData),
        .de_o             (de_o),
        .x_o              (x_o),
        .y_o              (y_o),
        .motion_flag      (motion_flag),
        .frame_motion_cnt (frame_motion_cnt),
        .prev_valid       (prev_valid)
    );

    typedef struct {
        logic de;
        int   x;
        int   y;
        logic flag;
        int   fcnt;
        logic pv;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    // reference model state
    int   m_prev [IMG_W*IMG_H];
    int   m_cnt = 0;
    int   m_fcnt = 0;
    bit   m_pv = 0;
    bit   m_seen = 0;
    bit   m_rawprev = 0;

    // DUT flag observations for the directed checks
    int   flag_total = 0;
    int   flag_in = 0;
    int   flag_odd = 0;
    int   reg_x0 = 0;
    int   reg_y0 = 0;

    function automatic exp_t zero_exp();
        exp_t e;
        e = '{de: 1'b0, x: 0, y: 0, flag: 1'b0, fcnt: 0, pv: 1'b0};
        return e;
    endfunction

    // One pixel through the model: what the outputs must show 2 cycles later.
    function automatic void model_step(input bit r, input bit d, input int x, input int y,
                                       input logic [15:0] data);
        exp_t e;
        bit   win;
        bit   raw;
        bit   flag;
        int   addr, luma, p, diff, lr, lg, lb;
        if (r) begin
            // reset also clears the outputs holding the previous pixel
            if (q.size() > 0) q[$] = zero_exp();
            m_cnt = 0; m_fcnt = 0; m_pv = 0; m_seen = 0; m_rawprev = 0;
            q.push_back(zero_exp());
            return;
        end
        win = d && (x < DW) && (y < DH);
        raw = 0;
        if (win) begin
            addr = IMG_W * (y / 2) + (x / 2);
            lr = int'(data[15:11]); lg = int'(data[10:5]); lb = int'(data[4:0]);
            luma = lr + lg + lb;
            p = m_prev[addr];
            diff = (luma > p) ? luma - p : p - luma;
            raw = m_pv && (diff > THRESH);
            if ((x % 2 == 1) && (y % 2 == 1)) m_prev[addr] = luma;
        end
`ifdef MOTION_HFILT_EN
        flag = raw && m_rawprev;
`else
        flag = raw;
`endif
        m_rawprev = raw;
        if (flag && m_cnt < CMAX) m_cnt++;
        if (win && x == 1 && y == 1) m_seen = 1;
        if (win && x == DW - 1 && y == DH - 1) begin
            m_fcnt = m_cnt;
            m_cnt = 0;
            if (m_seen) m_pv = 1;
        end
        e.de = d; e.x = x; e.y = y; e.flag = flag; e.fcnt = m_fcnt; e.pv = m_pv;
        q.push_back(e);
    endfunction

    function automatic logic [15:0] mk(input int luma);
        int r, g, b;
        r = (luma > 31) ? 31 : luma;
        g = (luma - r > 63) ? 63 : luma - r;
        b = luma - r - g;
        return {5'(r), 6'(g), 5'(b)};
    endfunction

    // mode 0: static grey, 1: single changed source pixel, 2: threshold steps, 3: random
    function automatic logic [15:0] pix(input int mode, input int fidx, input int csx,
                                        input int x, input int y);
        int sx, sy;
        sx = x / 2; sy = y / 2;
        case (mode)
            0: return 16'h8410;
            1: return (fidx == 1 && sx == csx && sy == 5) ? mk(40) : 16'h0000;
            2: begin
                if (fidx == 0 || sy != 2) return mk(30);
                case (sx)
                    2: return mk(50);
                    4: return mk(51);
                    6: return mk(10);
                    8: return mk(9);
                    default: return mk(30);
                endcase
            end
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic chk(input string n, input int act, input int expv);
        checks++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0d, need %0d", n, act, expv);
    endtask

    task automatic drive(input bit r, input bit d, input int x, input int y, input logic [15:0] data);
        @(negedge clk);
        reset = r; DE = d; x_pixel = 10'(x); y_pixel = 10'(y); imgData = data;
        model_step(r, d, x, y, data);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 16'h0000);
    endtask

    task automatic run_frame(input int mode, input int fidx, input int csx, input int rst_pos);
        for (int y = 0; y < VT; y++) begin
            for (int x = 0; x < HT; x++) begin
                bit d, r;
                d = (x < HDE) && (y < VDE);
                r = (y * HT + x == rst_pos);
                drive(r, d, x, y, d ? pix(mode, fidx, csx, x, y) : 16'($urandom));
                if (r) begin
                    @(posedge clk); #1;
                    chk("midreset_de_x_y_flag", int'(de_o) + int'(x_o) + int'(y_o) + int'(motion_flag), 0);
                    chk("midreset_fcnt", int'(frame_motion_cnt), 0);
                    chk("midreset_prev_valid", int'(prev_valid), 0);
                end
            end
        end
    endtask

    task automatic clear_obs(input int x0, input int y0);
        flag_total = 0; flag_in = 0; flag_odd = 0; reg_x0 = x0; reg_y0 = y0;
    endtask

    // Every-cycle comparison of DUT outputs against the model, 2 cycles after input.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (q.size() >= 2) begin
                e = q.pop_front();
                checks++;
                if (de_o === e.de && x_o === 10'(e.x) && y_o === 10'(e.y) &&
                    motion_flag === e.flag && frame_motion_cnt === 17'(e.fcnt) && prev_valid === e.pv)
                    passed++;
                else
                    $display("FAIL pipe_compare t=%0t: got de=%b x=%0d y=%0d flag=%b fcnt=%0d pv=%b, need de=%b x=%0d y=%0d flag=%b fcnt=%0d pv=%b",
                             $time, de_o, x_o, y_o, motion_flag, frame_motion_cnt, prev_valid,
                             e.de, e.x, e.y, e.flag, e.fcnt, e.pv);
                if (motion_flag === 1'b1) begin
                    flag_total++;
                    if (int'(x_o) >= reg_x0 && int'(x_o) <= reg_x0 + 1 &&
                        int'(y_o) >= reg_y0 && int'(y_o) <= reg_y0 + 1) flag_in++;
                    if (x_o[0]) flag_odd++;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < IMG_W * IMG_H; i++) m_prev[i] = 0;

        // reset state
        do_reset();
        chk("reset_prev_valid", int'(prev_valid), 0);
        chk("reset_fcnt", int'(frame_motion_cnt), 0);

        // static scene
        clear_obs(0, 0);
        run_frame(0, 0, 0, -1);
        chk("static_pv_after_f0", int'(prev_valid), 1);
        run_frame(0, 1, 0, -1);
        chk("static_fcnt_f1", int'(frame_motion_cnt), 0);
        run_frame(0, 2, 0, -1);
        chk("static_fcnt_f2", int'(frame_motion_cnt), 0);
        chk("static_flags", flag_total, 0);

        // single changed block at source (10,5)
        do_reset();
        run_frame(1, 0, 10, -1);
        clear_obs(20, 10);
        run_frame(1, 1, 10, -1);
        chk("block_fcnt", int'(frame_motion_cnt), E_BLK);
        chk("block_flags_in_region", flag_in, E_BLK);
        chk("block_flags_total", flag_total, E_BLK);
        chk("block_flags_odd_x", flag_odd, 2);

        // changed block at source column 0
        do_reset();
        run_frame(1, 0, 0, -1);
        clear_obs(0, 10);
        run_frame(1, 1, 0, -1);
        chk("col0_fcnt", int'(frame_motion_cnt), E_BLK);
        chk("col0_flags_total", flag_total, E_BLK);
        chk("col0_flags_at_x1", flag_odd, 2);

        // threshold boundary: diffs 20,21,20,21
        do_reset();
        run_frame(2, 0, 0, -1);
        clear_obs(0, 0);
        run_frame(2, 1, 0, -1);
        chk("thresh_fcnt", int'(frame_motion_cnt), E_THR);
        chk("thresh_flags", flag_total, E_THR);

        // mid-frame reset: the partial frame after it must not validate the RAM
        do_reset();
        run_frame(1, 0, 99, -1);
        run_frame(0, 0, 0, -1);
        chk("all_change_fcnt", int'(frame_motion_cnt), E_ALL);
        run_frame(1, 0, 99, 8 * HT + 5);
        clear_obs(0, 0);
        run_frame(0, 0, 0, -1);
        chk("post_reset_frame_flags", flag_total, 0);
        chk("post_reset_frame_pv", int'(prev_valid), 1);
        chk("post_reset_frame_fcnt", int'(frame_motion_cnt), 0);
        run_frame(1, 0, 99, -1);
        chk("post_reset_change_fcnt", int'(frame_motion_cnt), E_ALL);

        // random stream, including a reset partway through
        do_reset();
        run_frame(3, 0, 0, -1);
        run_frame(3, 0, 0, -1);
        run_frame(3, 0, 0, 5 * HT + 17);
        run_frame(3, 0, 0, -1);
        run_frame(3, 0, 0, -1);

        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 16'h0000);
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/frame_diff_detector.md
# frame_diff_detector

Per-pixel motion detector between the camera frame buffer read path and the centre-of-mass stage. It converts each displayed RGB565 pixel to luma and compares it with the same pixel from the previous frame, held in an internal 160×120 luma RAM. It then emits `motion_flag` together with `DE`, `x_pixel` and `y_pixel` delayed to match. The downstream coordinate and display stages consume the delayed signals so that each flag lines up with its own pixel.

## Interface
- `THRESH`, default 20: luma difference strictly greater than this sets the flag.
- `IMG_W`, default 160: source image width. The displayed area is 2×IMG_W.
- `IMG_H`, default 120: source image height. The displayed area is 2×IMG_H.
- `clk`  in  1  pixel clock, single clock domain.
- `reset`  in  1  synchronous, active-high.
- `DE`  in  1  VGA display enable.
- `x_pixel`  in  10  VGA column.
- `y_pixel`  in  10  VGA row.
- `imgData`  in  16  RGB565 pixel for the current (`x_pixel`, `y_pixel`). Valid in the same cycle.
- `de_o`  out  1  `DE` delayed 2 cycles.
- `x_o`  out  10  `x_pixel` delayed 2 cycles.
- `y_o`  out  10  `y_pixel` delayed 2 cycles.
- `motion_flag`  out  1  motion at (`x_o`, `y_o`).
- `frame_motion_cnt`  out  17  number of flagged displayed pixels in the last completed frame.
- `prev_valid`  out  1  previous-frame RAM holds a complete frame.

## Operation
- **Active window:** `DE && x_pixel < 2*IMG_W && y_pixel < 2*IMG_H`.
- **RAM address:** `IMG_W*y_pixel[9:1] + x_pixel[9:1]`, 15 bits. Each source pixel covers a 2×2 block of displayed pixels.
- **Luma:** `luma = imgData[15:11] + imgData[10:5] + imgData[4:0]`, zero-extended to 8 bits, range 0..125.
- **Pipeline, stage 0:**
  - Register `DE`/`x`/`y`, window bit, address, luma.
  - Issue a synchronous RAM read at the address.
- **Pipeline, stage 1:**
  - RAM data `prev` is available.
  - `diff = |luma - prev|`.
  - `raw = window && prev_valid && diff > THRESH`.
- **Pipeline, stage 2:** register `motion_flag` and delay outputs `de_o`/`x_o`/`y_o`.
- **Write-back:**
  - Current luma is written to the stage-1 address only when window and stage-1 `x[0]==1` and `y[0]==1`, i.e. the last displayed pixel of the 2×2 block.
  - The other three pixels of the block therefore always read previous-frame data.
  - Read and write addresses in the same cycle never coincide.
- **Frame end:** the write of the pixel at x=2*IMG_W-1, y=2*IMG_H-1.
  - Set `prev_valid`, which stays set until reset.
  - Latch the running counter into `frame_motion_cnt`.
  - Clear the running counter.
- **Running counter:** increments once per stage-2 cycle with `motion_flag=1`. It saturates at 2^17-1.
- **Outside the window:** `motion_flag=0`, no write, no count.
- **Reset (any time, including mid-frame):**
  - All pipeline registers, outputs, the counter, `frame_motion_cnt` and `prev_valid` go to 0.
  - RAM contents are not cleared. The next full frame rewrites them before any flag can assert.

## Timing
- Latency is 2 cycles, from `DE`/`x_pixel`/`y_pixel`/`imgData` to `de_o`/`x_o`/`y_o`/`motion_flag`.
- There is no handshake. The block accepts one pixel per clock, continuously.
- `frame_motion_cnt` updates 1 cycle after the frame-end write cycle.
- `prev_valid` rises in the same cycle as that update.
- **Frame 0 after reset:** `motion_flag=0` everywhere.
- **Frame 1:** first frame that can assert `motion_flag`.
- **Blanking:** pipeline keeps shifting, and `de_o=0` propagates.
- **Simultaneous frame end and flagged pixel:** the latched count includes that final pixel.

## Configuration
- **`MOTION_HFILT_EN` defined:**
  - `motion_flag = raw_s2 && raw_s2_prev`, where `raw_s2_prev` is the raw result of the immediately preceding displayed pixel on the same line.
  - `raw_s2_prev` is cleared whenever `de_o` is low or the pixel is outside the window, so the first pixel of each line can never flag.
  - Isolated single-pixel noise is suppressed.
  - Latency stays 2 cycles.
- **Undefined:** `motion_flag = raw`, no filtering.

## Test plan
- **Reset:** assert `reset` mid-frame.
  - Next cycle: all outputs are 0 and `prev_valid=0`.
  - The next full frame produces no flags.
- **Static scene:** three identical frames of constant `imgData=16'h8410`.
  - `prev_valid` rises after frame 0.
  - `motion_flag` is never 1.
  - `frame_motion_cnt=0` after frames 1 and 2.
- **Block change:** frame 1 changes source pixel (10,5) from luma 0 to luma 40.
  - `motion_flag=1` exactly at `x_o`∈{20,21}, `y_o`∈{10,11}, 2 cycles after the inputs.
  - `frame_motion_cnt=4` with the macro undefined.
- **Threshold boundary:** luma difference 20 gives no flag; difference 21 gives a flag, with `THRESH=20`.
- **Latency and alignment:** random `imgData` stream.
  - `x_o`/`y_o`/`de_o` equal the inputs from 2 cycles earlier every cycle, including blanking.
- **`MOTION_HFILT_EN` defined:**
  - Single changed source pixel: flags only at x_o=21, y_o∈{10,11}, so `frame_motion_cnt=2`.
  - Changed pixel at source column 0: flags at x_o=1 only.
